// File: rtl/vscale_htif_pcr_master_pkg.sv
// vscale_htif_pcr_master_pkg: shared widths, CSR addresses and FSM/source encodings for the HTIF PCR master.
package vscale_htif_pcr_master_pkg;
  localparam int CSR_ADDR_WIDTH = 12;
  localparam int HTIF_PCR_WIDTH = 64;
  localparam int XPR_LEN = 32;
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_ADDR_TO_HOST = 12'h780;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;
  typedef enum logic {SRC_CMD, SRC_POLL} src_e;
endpackage

// File: rtl/vscale_htif_poll_timer.sv
// vscale_htif_poll_timer: free-running poll interval counter with a non-queuing poll_pending flag.
module vscale_htif_poll_timer #(
  parameter int POLL_INTERVAL = 256
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic en_i,
  input  logic clr_i,
  output logic pending_o
);
  localparam int CW = $clog2(POLL_INTERVAL);
  logic [CW-1:0] cnt_q, cnt_d;
  logic pending_q, pending_d, wrap;
  always_comb begin
    wrap = cnt_q == CW'(POLL_INTERVAL - 1);
    cnt_d = (!en_i || wrap) ? '0 : cnt_q + CW'(1);
    pending_d = en_i && (wrap || (pending_q && !clr_i));
  end
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      cnt_q <= '0;
      pending_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pending_q <= pending_d;
    end
  end
  assign pending_o = pending_q;
endmodule

// File: rtl/vscale_htif_pcr_master.sv
// vscale_htif_pcr_master: turns host CSR commands and periodic TO_HOST polls into single HTIF PCR transactions.
module vscale_htif_pcr_master
  import vscale_htif_pcr_master_pkg::*;
#(
  parameter int POLL_INTERVAL = 256,
  parameter logic [CSR_ADDR_WIDTH-1:0] TOHOST_ADDR = CSR_ADDR_TO_HOST
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      poll_enable_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_rw_i,
  input  logic [CSR_ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [HTIF_PCR_WIDTH-1:0] cmd_wdata_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [HTIF_PCR_WIDTH-1:0] rsp_data_o,
  output logic                      tohost_valid_o,
  input  logic                      tohost_ready_i,
  output logic [XPR_LEN-1:0]        tohost_data_o,
  output logic                      tohost_overflow_o,
  output logic                      htif_pcr_req_valid_o,
  input  logic                      htif_pcr_req_ready_i,
  output logic                      htif_pcr_req_rw_o,
  output logic [CSR_ADDR_WIDTH-1:0] htif_pcr_req_addr_o,
  output logic [HTIF_PCR_WIDTH-1:0] htif_pcr_req_data_o,
  input  logic                      htif_pcr_resp_valid_i,
  output logic                      htif_pcr_resp_ready_o,
  input  logic [HTIF_PCR_WIDTH-1:0] htif_pcr_resp_data_i
);
  state_e state_q, state_d;
  src_e src_q, src_d;
  logic rw_q, rw_d;
  logic [CSR_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [HTIF_PCR_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic th_valid_q, th_valid_d, ovf_q, ovf_d;
  logic [XPR_LEN-1:0] th_data_q, th_data_d;
  logic poll_pending, poll_issue, poll_hit;
  vscale_htif_poll_timer #(.POLL_INTERVAL(POLL_INTERVAL)) u_timer (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .en_i     (poll_enable_i),
    .clr_i    (poll_issue),
    .pending_o(poll_pending)
  );
  always_comb begin
    state_d = state_q;
    src_d = src_q;
    rw_d = rw_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    poll_issue = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          rw_d = cmd_rw_i;
          addr_d = cmd_addr_i;
          wdata_d = cmd_wdata_i;
          src_d = SRC_CMD;
          state_d = REQ;
        end else if (poll_pending) begin
          rw_d = 1'b0;
          addr_d = TOHOST_ADDR;
          wdata_d = '0;
          src_d = SRC_POLL;
          poll_issue = 1'b1;
          state_d = REQ;
        end
      end
      REQ: state_d = htif_pcr_req_ready_i ? WAIT : REQ;
      WAIT: begin
        if (htif_pcr_resp_valid_i) begin
          rdata_d = htif_pcr_resp_data_i;
          state_d = src_q == SRC_CMD ? DONE : IDLE;
        end
      end
      DONE: state_d = rsp_ready_i ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    // A fresh nonzero poll result always wins; overflow only if the previous one was still unconsumed.
    poll_hit = state_q == WAIT && htif_pcr_resp_valid_i && src_q == SRC_POLL && |htif_pcr_resp_data_i;
    th_valid_d = poll_hit || (th_valid_q && !tohost_ready_i);
    th_data_d = poll_hit ? htif_pcr_resp_data_i[XPR_LEN-1:0] : th_data_q;
    ovf_d = ovf_q || (poll_hit && th_valid_q && !tohost_ready_i);
  end
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      src_q <= SRC_CMD;
      rw_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      th_valid_q <= 1'b0;
      th_data_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q <= src_d;
      rw_q <= rw_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      th_valid_q <= th_valid_d;
      th_data_q <= th_data_d;
      ovf_q <= ovf_d;
    end
  end
  assign cmd_ready_o = reset_i && state_q == IDLE;
  assign htif_pcr_req_valid_o = state_q == REQ;
  assign htif_pcr_req_rw_o = rw_q;
  assign htif_pcr_req_addr_o = addr_q;
  assign htif_pcr_req_data_o = wdata_q;
  assign htif_pcr_resp_ready_o = state_q == WAIT;
  assign rsp_valid_o = state_q == DONE;
  assign rsp_data_o = rdata_q;
  assign tohost_valid_o = th_valid_q;
  assign tohost_data_o = th_data_q;
  assign tohost_overflow_o = ovf_q;
endmodule
